// File: rtl/shift_agc_pkg.sv
// Shared definitions for the shift_agc automatic gain control block:
// the controller state encoding and the "no MSB found" sentinel.
package shift_agc_pkg;

  // Controller phases: accumulate a block, evaluate its peak, apply the new shift.
  typedef enum logic [1:0] {
    ACCUM = 2'd0,
    EVAL  = 2'd1,
    APPLY = 2'd2
  } agc_state_t;

  // Index reported when a block peak is zero. Cast to the index width it
  // becomes all-ones, which can never be a real bit position.
  localparam int NO_MSB = -1;

endpackage : shift_agc_pkg

// File: rtl/shift_agc_msb_index.sv
// Combinational priority encoder: index of the highest set bit of vec,
// plus a flag that is set when vec has no bits set at all.
module shift_agc_msb_index
  import shift_agc_pkg::*;
#(
  parameter int W     = 39,
  parameter int IDX_W = 6
) (
  input  logic [W-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             zero
);

  // Ascending scan so the highest set bit is the last one to write idx.
  always_comb begin
    idx  = '0;
    zero = ~|vec;
    for (int i = 0; i < W; i++) begin
      if (vec[i]) idx = IDX_W'(i);
    end
  end

endmodule : shift_agc_msb_index

// File: rtl/shift_agc.sv
// Automatic gain control for a word-select shifter. Watches the wide signed
// accumulator samples, ORs their magnitudes over fixed blocks, and steers
// the shift so the OUT_W-bit window holds the peak without clipping.
// Attack is immediate; decay is one step after HOLD quiet blocks.
//
// Interface semantics: en is a valid-only strobe with no back-pressure.
// A sample is consumed on every ck edge where en=1 and rst=0; the block
// is always ready, including while a previous block is being evaluated.
module shift_agc
  import shift_agc_pkg::*;
#(
  parameter int IN_W      = 40,
  parameter int OUT_W     = 16,
  parameter int SHIFT_W   = 5,
  parameter int BLOCK_W   = 10,
  parameter int HOLD      = 4,
  parameter int MAX_SHIFT = 24
) (
  input  logic               ck,
  input  logic               rst,
  input  logic               en,
  input  logic [IN_W-1:0]    in,
  output logic [SHIFT_W-1:0] shift,
  output logic               update,
  output logic               clip,
  output logic [SHIFT_W:0]   peak_msb
);

  localparam int MAG_W  = IN_W - 1;
  localparam int PMSB_W = SHIFT_W + 1;

  // Controller phase; kept as a named signal so checkers can bind to it.
  agc_state_t state;

  logic [MAG_W-1:0]   mag;
  logic [MAG_W-1:0]   peak_acc;
  logic [MAG_W-1:0]   peak_hold;
  logic [BLOCK_W-1:0] count;
  logic               block_end;
  logic [PMSB_W-1:0]  clip_thr;
  logic               over;

  logic [PMSB_W-1:0]  p_idx;
  logic               p_zero;
  logic [PMSB_W-1:0]  p_excess;
  logic [SHIFT_W-1:0] req_c;
  logic [SHIFT_W-1:0] req;
  logic [7:0]         hold;
  logic [8:0]         hold_inc;

  // One's complement magnitude: cannot overflow on the most negative input.
  assign mag = in[IN_W-1] ? ~in[MAG_W-1:0] : in[MAG_W-1:0];

  // The window holds bits up to shift+OUT_W-2 plus sign; anything at or
  // above shift+OUT_W-1 would clip at the current shift.
  assign clip_thr = PMSB_W'(shift) + PMSB_W'(OUT_W - 1);
  assign over     = |(mag >> clip_thr);

  assign block_end = en && (count == {BLOCK_W{1'b1}});

  // Peak of the completed block, looked at during EVAL.
  shift_agc_msb_index #(
    .W     (MAG_W),
    .IDX_W (PMSB_W)
  ) u_msb (
    .vec  (peak_hold),
    .idx  (p_idx),
    .zero (p_zero)
  );

  // Requested shift: how far the peak MSB sits above the top magnitude bit
  // of the window, floored at 0 and clamped to MAX_SHIFT.
  always_comb begin
    p_excess = '0;
    req_c    = '0;
    if (!p_zero && (p_idx > PMSB_W'(OUT_W - 2))) begin
      p_excess = p_idx - PMSB_W'(OUT_W - 2);
      if (p_excess > PMSB_W'(MAX_SHIFT)) req_c = SHIFT_W'(MAX_SHIFT);
      else                               req_c = p_excess[SHIFT_W-1:0];
    end
  end

  assign hold_inc = {1'b0, hold} + 9'd1;

  // Sample path: block peak accumulation, sample counting and clip flag.
  // Runs in every phase so samples arriving during EVAL/APPLY are kept.
  always_ff @(posedge ck) begin
    if (rst) begin
      peak_acc  <= '0;
      peak_hold <= '0;
      count     <= '0;
      clip      <= 1'b0;
    end else begin
      clip <= en && over;
      if (en) begin
        if (block_end) begin
          peak_hold <= peak_acc | mag;
          peak_acc  <= '0;
          count     <= '0;
        end else begin
          peak_acc <= peak_acc | mag;
          count    <= count + 1'b1;
        end
      end
    end
  end

  // Gain controller: evaluate the latched peak, then attack or decay shift.
  always_ff @(posedge ck) begin
    if (rst) begin
      state    <= ACCUM;
      shift    <= SHIFT_W'(MAX_SHIFT);
      update   <= 1'b0;
      peak_msb <= PMSB_W'(NO_MSB);
      hold     <= '0;
      req      <= '0;
    end else begin
      update <= 1'b0;
      case (state)
        ACCUM: begin
          if (block_end) state <= EVAL;
        end
        EVAL: begin
          peak_msb <= p_zero ? PMSB_W'(NO_MSB) : p_idx;
          req      <= req_c;
          state    <= APPLY;
        end
        APPLY: begin
          if (req > shift) begin
            // Louder block: jump straight to the required shift.
            shift  <= req;
            hold   <= '0;
            update <= 1'b1;
          end else if (req < shift) begin
            // Quieter block: only step down after HOLD in a row.
            if (hold_inc == 9'(HOLD)) begin
              shift  <= shift - 1'b1;
              hold   <= '0;
              update <= 1'b1;
            end else begin
              hold <= hold_inc[7:0];
            end
          end else begin
            hold <= '0;
          end
          state <= ACCUM;
        end
        default: state <= ACCUM;
      endcase
    end
  end

endmodule : shift_agc

// File: tb/tb_shift_agc.sv
// Self-checking bench for shift_agc with BLOCK_W=2 (4-sample blocks), HOLD=2.
// A block-level reference model predicts every output after every edge.
module tb_shift_agc;

  localparam int IN_W = 40, OUT_W = 16, SHIFT_W = 5, BLOCK_W = 2;
  localparam int HOLD = 2, MAX_SHIFT = 24;
  localparam int BLK = 1 << BLOCK_W;

  logic               ck;
  logic               rst;
  logic               en;
  logic [IN_W-1:0]    smp;
  logic [SHIFT_W-1:0] shift;
  logic               update;
  logic               clip;
  logic [SHIFT_W:0]   peak_msb;

  int tests = 0;
  int fails = 0;

  // Reference model state
  int     m_shift, m_hold, m_peak_msb, m_req;
  bit     m_update, m_clip;
  longint blk_max, eval_peak;
  int     blk_n;
  int     cd;

  shift_agc #(
    .IN_W(IN_W), .OUT_W(OUT_W), .SHIFT_W(SHIFT_W), .BLOCK_W(BLOCK_W),
    .HOLD(HOLD), .MAX_SHIFT(MAX_SHIFT)
  ) dut (
    .ck(ck), .rst(rst), .en(en), .in(smp),
    .shift(shift), .update(update), .clip(clip), .peak_msb(peak_msb)
  );

  // Clock and watchdog
  initial begin
    ck = 1'b0;
    forever #5 ck = ~ck;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

  // Magnitude as |x|-1 for negatives, |x| otherwise.
  function automatic longint magf(input logic [IN_W-1:0] x);
    longint sx;
    sx = longint'(signed'(x));
    return (sx < 0) ? (-sx - 1) : sx;
  endfunction

  // Largest i with 2^i <= v, or -1 for zero.
  function automatic int msbf(input longint v);
    int r;
    r = -1;
    for (int i = 0; i < 62; i++) if (v >= (longint'(1) << i)) r = i;
    return r;
  endfunction

  task automatic model_reset();
    m_shift = MAX_SHIFT; m_hold = 0; m_peak_msb = -1; m_req = 0;
    m_update = 0; m_clip = 0; blk_max = 0; eval_peak = 0; blk_n = 0; cd = -1;
  endtask

  // Drive one cycle, then advance the model to the post-edge values.
  task automatic tick(input bit r, input bit e, input logic [IN_W-1:0] x);
    @(negedge ck);
    rst = r; en = e; smp = x;
    @(posedge ck);
    if (r) begin
      model_reset();
    end else begin
      m_update = 0;
      m_clip = e && (magf(x) >= (longint'(1) << (m_shift + OUT_W - 1)));
      if (cd == 1) begin
        if (m_req > m_shift) begin
          m_shift = m_req; m_hold = 0; m_update = 1;
        end else if (m_req < m_shift) begin
          m_hold++;
          if (m_hold == HOLD) begin m_shift--; m_hold = 0; m_update = 1; end
        end else begin
          m_hold = 0;
        end
        cd = -1;
      end else if (cd == 0) begin
        m_peak_msb = msbf(eval_peak);
        m_req = m_peak_msb - (OUT_W - 2);
        if (m_req < 0) m_req = 0;
        if (m_req > MAX_SHIFT) m_req = MAX_SHIFT;
        cd = 1;
      end
      if (e) begin
        if (magf(x) > blk_max) blk_max = magf(x);
        blk_n++;
        if (blk_n == BLK) begin
          eval_peak = blk_max; blk_max = 0; blk_n = 0; cd = 0;
        end
      end
    end
    #1;
  endtask

  task automatic test_reset();
    tick(1, 0, '0);
    tick(1, 1, 40'hFF_FFFF_FFFF);
    tests += 4;
    if (shift !== 5'd24) begin fails++; $display("FAIL reset shift act=%0d exp=24", shift); end
    if (update !== 1'b0) begin fails++; $display("FAIL reset update act=%0b exp=0", update); end
    if (clip !== 1'b0) begin fails++; $display("FAIL reset clip act=%0b exp=0", clip); end
    if (peak_msb !== 6'h3F) begin fails++; $display("FAIL reset peak_msb act=%0d exp=63", peak_msb); end
  endtask

  task automatic test_hold_decay();
    bit seen_early;
    seen_early = 0;
    for (int c = 0; c < 2 * BLK + 3; c++) begin
      tick(0, c < 2 * BLK, 40'h00_0010_0000);
      tests += 4;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL hold shift act=%0d exp=%0d", shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL hold update act=%0b exp=%0b", update, m_update); end
      if (clip !== m_clip) begin fails++; $display("FAIL hold clip act=%0b exp=%0b", clip, m_clip); end
      if (peak_msb !== 6'(m_peak_msb)) begin fails++; $display("FAIL hold peak_msb act=%0d exp=%0d", peak_msb, m_peak_msb); end
      if (c < 2 * BLK + 1 && update === 1'b1) seen_early = 1;
      if (c == 2 * BLK + 1) begin
        tests += 2;
        if (shift !== 5'd23 || update !== 1'b1) begin fails++; $display("FAIL hold decay_step shift=%0d update=%0b exp 23/1", shift, update); end
        if (seen_early) begin fails++; $display("FAIL hold early_update act=1 exp=0"); end
      end
    end
    tests++;
    if (peak_msb !== 6'd20) begin fails++; $display("FAIL hold peak20 act=%0d exp=20", peak_msb); end
  endtask

  task automatic test_clip_attack();
    int c;
    c = 0;
    while (m_shift != 6 && c < 400) begin
      tick(0, 1, '0);
      c++;
      tests += 2;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL preload shift act=%0d exp=%0d", shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL preload update act=%0b exp=%0b", update, m_update); end
    end
    tests++;
    if (shift !== 5'd6) begin fails++; $display("FAIL preload reach6 act=%0d exp=6", shift); end
    tick(0, 1, 40'h00_4000_0000);
    tests++;
    if (clip !== 1'b1) begin fails++; $display("FAIL clip pulse act=%0b exp=1", clip); end
    for (int k = 0; k < BLK + 3; k++) begin
      tick(0, k < BLK - 1, '0);
      tests += 4;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL attack shift act=%0d exp=%0d", shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL attack update act=%0b exp=%0b", update, m_update); end
      if (clip !== m_clip) begin fails++; $display("FAIL attack clip act=%0b exp=%0b", clip, m_clip); end
      if (peak_msb !== 6'(m_peak_msb)) begin fails++; $display("FAIL attack peak_msb act=%0d exp=%0d", peak_msb, m_peak_msb); end
    end
    tests++;
    if (shift !== 5'd16) begin fails++; $display("FAIL attack shift16 act=%0d exp=16", shift); end
  endtask

  task automatic test_negative();
    tick(1, 0, '0);
    for (int k = 0; k < BLK + 3; k++) begin
      tick(0, k < BLK, 40'hFF_FFF0_0000);
      tests += 2;
      if (clip !== m_clip) begin fails++; $display("FAIL neg clip act=%0b exp=%0b", clip, m_clip); end
      if (update !== m_update) begin fails++; $display("FAIL neg update act=%0b exp=%0b", update, m_update); end
    end
    tests += 3;
    if (peak_msb !== 6'd19) begin fails++; $display("FAIL neg peak_msb act=%0d exp=19", peak_msb); end
    if (shift !== 5'd24) begin fails++; $display("FAIL neg shift act=%0d exp=24", shift); end
    if (m_req != 5) begin fails++; $display("FAIL neg req model=%0d exp=5", m_req); end
  endtask

  task automatic test_zero_decay();
    int ups;
    ups = 0;
    tick(1, 0, '0);
    for (int k = 0; k < 60 * BLK + 3; k++) begin
      tick(0, k < 60 * BLK, '0);
      if (update === 1'b1) ups++;
      tests += 4;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL zero shift act=%0d exp=%0d", shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL zero update act=%0b exp=%0b", update, m_update); end
      if (clip !== m_clip) begin fails++; $display("FAIL zero clip act=%0b exp=%0b", clip, m_clip); end
      if (peak_msb !== 6'(m_peak_msb)) begin fails++; $display("FAIL zero peak_msb act=%0d exp=%0d", peak_msb, m_peak_msb); end
    end
    tests += 3;
    if (shift !== 5'd0) begin fails++; $display("FAIL zero final_shift act=%0d exp=0", shift); end
    if (ups != 24) begin fails++; $display("FAIL zero update_count act=%0d exp=24", ups); end
    if (peak_msb !== 6'h3F) begin fails++; $display("FAIL zero peak_msb_final act=%0d exp=63", peak_msb); end
  endtask

  task automatic test_overlap();
    logic [IN_W-1:0] seq [0:6];
    seq[0] = '0; seq[1] = '0; seq[2] = '0; seq[3] = 40'h00_0010_0000;
    seq[4] = 40'h00_0001_0000; seq[5] = 40'h00_0004_0000; seq[6] = 40'h00_0004_0000;
    for (int k = 0; k < 10; k++) begin
      tick(0, k < 8, (k < 7) ? seq[k] : '0);
      tests += 4;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL overlap shift act=%0d exp=%0d", shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL overlap update act=%0b exp=%0b", update, m_update); end
      if (clip !== m_clip) begin fails++; $display("FAIL overlap clip act=%0b exp=%0b", clip, m_clip); end
      if (peak_msb !== 6'(m_peak_msb)) begin fails++; $display("FAIL overlap peak_msb act=%0d exp=%0d", peak_msb, m_peak_msb); end
      if (k == 4 || k == 5) begin
        tests++;
        if (clip !== 1'b1) begin fails++; $display("FAIL overlap old_shift_clip k=%0d act=%0b exp=1", k, clip); end
      end
      if (k == 5) begin
        tests++;
        if (shift !== 5'd6) begin fails++; $display("FAIL overlap attack act=%0d exp=6", shift); end
      end
      if (k == 6) begin
        tests++;
        if (clip !== 1'b0) begin fails++; $display("FAIL overlap new_shift_clip act=%0b exp=0", clip); end
      end
    end
    tests++;
    if (peak_msb !== 6'd18) begin fails++; $display("FAIL overlap next_peak act=%0d exp=18", peak_msb); end
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 2; k++) begin
      repeat ($urandom_range(0, 3)) tick(0, 0, 40'h00_4000_0000);
      tick(0, 1, 40'h00_4000_0000);
    end
    tick(1, 0, '0);
    tests += 4;
    if (shift !== 5'd24) begin fails++; $display("FAIL rstmid shift act=%0d exp=24", shift); end
    if (update !== 1'b0) begin fails++; $display("FAIL rstmid update act=%0b exp=0", update); end
    if (clip !== 1'b0) begin fails++; $display("FAIL rstmid clip act=%0b exp=0", clip); end
    if (peak_msb !== 6'h3F) begin fails++; $display("FAIL rstmid peak_msb act=%0d exp=63", peak_msb); end
    for (int k = 0; k < BLK - 1; k++) begin
      repeat ($urandom_range(1, 4)) tick(0, 0, 40'h7F_FFFF_FFFF);
      tick(0, 1, 40'h00_0200_0000);
    end
    repeat (4) tick(0, 0, '0);
    tests++;
    if (peak_msb !== 6'h3F) begin fails++; $display("FAIL rstmid partial_block act=%0d exp=63", peak_msb); end
    tick(0, 1, 40'h00_0200_0000);
    tick(0, 0, '0);
    tick(0, 0, '0);
    tests += 2;
    if (peak_msb !== 6'd25) begin fails++; $display("FAIL rstmid block_peak act=%0d exp=25", peak_msb); end
    if (shift !== 5'd24) begin fails++; $display("FAIL rstmid shift_after act=%0d exp=24", shift); end
  endtask

  task automatic test_random();
    for (int k = 0; k < 1200; k++) begin
      int w;
      longint v;
      bit r, e;
      w = $urandom_range(0, 39);
      v = longint'({$urandom(), $urandom()}) & ((longint'(1) << w) - 1);
      if ($urandom_range(0, 1) == 1) v = -v - 1;
      r = ($urandom_range(0, 299) == 0);
      e = ($urandom_range(0, 9) < 7);
      tick(r, e, v[IN_W-1:0]);
      tests += 4;
      if (shift !== 5'(m_shift)) begin fails++; $display("FAIL random shift k=%0d act=%0d exp=%0d", k, shift, m_shift); end
      if (update !== m_update) begin fails++; $display("FAIL random update k=%0d act=%0b exp=%0b", k, update, m_update); end
      if (clip !== m_clip) begin fails++; $display("FAIL random clip k=%0d act=%0b exp=%0b", k, clip, m_clip); end
      if (peak_msb !== 6'(m_peak_msb)) begin fails++; $display("FAIL random peak_msb k=%0d act=%0d exp=%0d", k, peak_msb, m_peak_msb); end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; smp = '0;
    model_reset();
    test_reset();
    test_hold_decay();
    test_clip_attack();
    test_negative();
    test_zero_decay();
    test_overlap();
    test_reset_mid();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule : tb_shift_agc
